// File: rtl/wb_commit_stage_pkg.sv
// wb_commit_stage_pkg: shared state encodings, exception codes and queue entry layout
package wb_commit_stage_pkg;
  typedef enum logic {RUN, FLUSH} state_t;
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_IPE  = 6'h0E;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_TAB [15:1] = '{ECODE_INT, ECODE_ADE, ECODE_TLBR, ECODE_PIF, ECODE_PPI,
                                               ECODE_SYS, ECODE_BRK, ECODE_INE, ECODE_IPE, ECODE_ALE,
                                               ECODE_TLBR, ECODE_PME, ECODE_PPI, ECODE_PIS, ECODE_PIL};
  typedef struct packed {
    logic [31:0] pc;
    logic        ertn;
    logic [4:0]  dest;
    logic        gr_we;
    logic        res_from_csr;
    logic [31:0] result;
    logic        excp;
    logic [15:0] excp_num;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
  } wb_entry_t;
  function automatic logic [5:0] ecode_enc(input logic [15:1] v);
    ecode_enc = 6'h00;
    for (int i = 1; i <= 15; i++)
      if (v[i]) ecode_enc = ECODE_TAB[i];
  endfunction
endpackage

// File: rtl/wb_commit_stage_fifo.sv
// wb_commit_stage_fifo: circular entry queue with clear and a flat per-slot view
module wb_commit_stage_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         valid,
  output logic [DEPTH*W-1:0]       entries
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    rd_d = clear ? '0 : rd_q + AW'(pop);
    wr_d = clear ? '0 : wr_q + AW'(push);
    cnt_d = clear ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign head = mem_q[rd_q];
  assign count = cnt_q;
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign valid[i] = {1'b0, AW'(i) - rd_q} < cnt_q;
    assign entries[i*W +: W] = mem_q[i];
  end
endmodule

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: queued writeback/commit with exception/ertn flush, retire counter and pending-dest vector
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic             in_ertn,
  input  logic [4:0]       in_dest,
  input  logic             in_gr_we,
  input  logic             in_res_from_csr,
  input  logic [31:0]      in_result,
  input  logic             in_excp,
  input  logic [15:0]      in_excp_num,
  input  logic             in_csr_we,
  input  logic [13:0]      in_csr_num,
  input  logic [31:0]      in_csr_wmask,
  input  logic [31:0]      in_csr_wdata,
  input  logic             commit_stall,
  input  logic [31:0]      csr_rdata,
  output logic             csr_we,
  output logic [13:0]      csr_num,
  output logic [31:0]      csr_wmask,
  output logic [31:0]      csr_wdata,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             excp_flush,
  output logic             ertn_flush,
  output logic [5:0]       ecode,
  output logic [31:0]      epc,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [31:0]      busy_dest_vec,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
);
  localparam int W = $bits(wb_entry_t);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  wb_entry_t din, head, slot;
  logic [AW:0] count;
  logic [FIFO_DEPTH-1:0] valid;
  logic [FIFO_DEPTH*W-1:0] entries;
  state_t state_q, state_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] busy;
  logic commit, commit_flush, push, unused;
  assign din = '{pc: in_pc, ertn: in_ertn, dest: in_dest, gr_we: in_gr_we, res_from_csr: in_res_from_csr,
                 result: in_result, excp: in_excp, excp_num: in_excp_num, csr_we: in_csr_we,
                 csr_num: in_csr_num, csr_wmask: in_csr_wmask, csr_wdata: in_csr_wdata};
  wb_commit_stage_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(commit), .clear(commit_flush), .din(din),
    .head(head), .count(count), .valid(valid), .entries(entries)
  );
  always_comb begin
    commit = count != '0 && !commit_stall && state_q == RUN;
    excp_flush = commit && head.excp;
    ertn_flush = commit && head.ertn && !head.excp;
    commit_flush = excp_flush || ertn_flush;
    in_ready = state_q == RUN && count < (AW+1)'(FIFO_DEPTH) && !commit_flush;
    push = in_valid && in_ready;
    rf_we = commit && head.gr_we && !head.excp;
    rf_waddr = head.dest;
    rf_wdata = head.res_from_csr ? csr_rdata : head.result;
    csr_we = commit && head.csr_we && !head.excp;
    csr_num = head.csr_num;
    csr_wmask = head.csr_wmask;
    csr_wdata = head.csr_wdata;
    ecode = ecode_enc(head.excp_num[15:1]);
    epc = head.pc;
    state_d = commit_flush ? FLUSH : (state_q == FLUSH && flush_cnt_q == FW'(1)) ? RUN : state_q;
    flush_cnt_d = commit_flush ? FW'(FLUSH_CYCLES) : state_q == FLUSH ? flush_cnt_q - FW'(1) : flush_cnt_q;
    retire_cnt_d = retire_cnt_q + CNT_W'(commit && !head.excp);
    retire_cnt = retire_cnt_q;
    debug_wb_pc = head.pc;
    debug_wb_rf_we = {4{rf_we}};
    debug_wb_rf_wnum = head.dest;
    debug_wb_rf_wdata = rf_wdata;
  end
  always_comb begin
    busy = '0;
    slot = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot = wb_entry_t'(entries[i*W +: W]);
      if (valid[i] && slot.gr_we && !slot.excp) busy[slot.dest] = 1'b1;
    end
    busy_dest_vec = {busy[31:1], 1'b0};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      flush_cnt_q <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      flush_cnt_q <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end
  assign unused = ^{head.excp_num[0], slot};
endmodule

// File: tb/tb_wb_commit_stage.sv
// tb_wb_commit_stage: directed vectors with a commit scoreboard for wb_commit_stage
module tb_wb_commit_stage;
  typedef struct {
    logic [31:0] pc;
    logic        ertn;
    logic [4:0]  dest;
    logic        gr_we;
    logic        rfc;
    logic [31:0] result;
    logic        excp;
    logic [15:0] en;
    logic        cwe;
    logic [13:0] cnum;
    logic [31:0] cmask;
    logic [31:0] cdata;
  } vec_t;
  typedef struct packed {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_we;
    logic [31:0] cmask;
    logic [31:0] cdata;
    logic        xf;
    logic        ef;
    logic [5:0]  ecode;
    logic [31:0] epc;
  } exp_t;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ertn = 0, in_gr_we = 0, in_res_from_csr = 0, in_excp = 0, in_csr_we = 0;
  logic commit_stall = 0;
  logic [31:0] in_pc = 0, in_result = 0, in_csr_wmask = 0, in_csr_wdata = 0;
  logic [4:0] in_dest = 0;
  logic [15:0] in_excp_num = 0;
  logic [13:0] in_csr_num = 0;
  logic [31:0] csr_rdata;
  logic in_ready, csr_we, rf_we, excp_flush, ertn_flush, debug_wb_rf_we_unused;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wdata, rf_wdata, epc, busy_dest_vec, debug_wb_pc, debug_wb_rf_wdata;
  logic [4:0] rf_waddr, debug_wb_rf_wnum;
  logic [5:0] ecode;
  logic [3:0] retire_cnt, debug_wb_rf_we;
  int checks = 0, failures = 0;
  exp_t expq[$];
  exp_t got_m, exp_m;
  assign csr_rdata = (csr_num == 14'h006) ? 32'hDEADBEEF : 32'h0;
  always #5 clk = ~clk;
  wb_commit_stage #(.FIFO_DEPTH(2), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ertn(in_ertn),
    .in_dest(in_dest), .in_gr_we(in_gr_we), .in_res_from_csr(in_res_from_csr), .in_result(in_result),
    .in_excp(in_excp), .in_excp_num(in_excp_num), .in_csr_we(in_csr_we), .in_csr_num(in_csr_num),
    .in_csr_wmask(in_csr_wmask), .in_csr_wdata(in_csr_wdata), .commit_stall(commit_stall),
    .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .ecode(ecode), .epc(epc), .retire_cnt(retire_cnt), .busy_dest_vec(busy_dest_vec),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );
  assign debug_wb_rf_we_unused = ^{debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata};
  function automatic vec_t mk_v(logic [31:0] pc, logic [4:0] dest, logic gr_we, logic [31:0] result);
    vec_t v;
    v = '{pc: pc, ertn: 0, dest: dest, gr_we: gr_we, rfc: 0, result: result, excp: 0, en: 0,
          cwe: 0, cnum: 0, cmask: 0, cdata: 0};
    return v;
  endfunction
  function automatic exp_t mk_x(logic rwe, logic [4:0] wa, logic [31:0] wd, logic cwe, logic [31:0] cm,
                                logic [31:0] cd, logic xf, logic ef, logic [5:0] ec, logic [31:0] pc);
    return '{rf_we: rwe, waddr: wa, wdata: wd, csr_we: cwe, cmask: cm, cdata: cd, xf: xf, ef: ef, ecode: ec, epc: pc};
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  task automatic send(input vec_t v, input bit has_x, input exp_t x);
    int n;
    n = 0;
    in_valid = 1; in_pc = v.pc; in_ertn = v.ertn; in_dest = v.dest; in_gr_we = v.gr_we;
    in_res_from_csr = v.rfc; in_result = v.result; in_excp = v.excp; in_excp_num = v.en;
    in_csr_we = v.cwe; in_csr_num = v.cnum; in_csr_wmask = v.cmask; in_csr_wdata = v.cdata;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout pc=%h", v.pc);
      in_valid = 0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 0;
    if (has_x) expq.push_back(x);
  endtask
  always @(negedge clk) begin
    if (!reset && (rf_we || csr_we || excp_flush || ertn_flush)) begin
      got_m = '{rf_we: rf_we, waddr: rf_waddr, wdata: rf_wdata, csr_we: csr_we, cmask: csr_wmask,
                cdata: csr_wdata, xf: excp_flush, ef: ertn_flush, ecode: ecode, epc: epc};
      if (!got_m.rf_we) begin got_m.waddr = '0; got_m.wdata = '0; end
      if (!got_m.csr_we) begin got_m.cmask = '0; got_m.cdata = '0; end
      if (!got_m.xf) got_m.ecode = '0;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected got=%h", got_m);
      end else begin
        exp_m = expq.pop_front();
        if (got_m !== exp_m) begin
          failures++;
          $display("FAIL commit_record got=%h want=%h", got_m, exp_m);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v;
    exp_t none;
    none = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_busy", busy_dest_vec, 0);
    chk("rst_strobes", {rf_we, csr_we, excp_flush, ertn_flush}, 0);
    for (int k = 1; k <= 4; k++) begin
      send(mk_v(32'h1c000000 + 4 * k, 5'(k), 1, 32'h11 * k), 1,
           mk_x(1, 5'(k), 32'h11 * k, 0, 0, 0, 0, 0, 0, 32'h1c000000 + 4 * k));
      chk($sformatf("lat_r%0d", k), {rf_we, rf_waddr}, {1'b1, 5'(k)});
    end
    @(posedge clk); #1;
    chk("b2b_retire", retire_cnt, 4);
    commit_stall = 1;
    send(mk_v(32'h1c000020, 6, 1, 32'h66), 1, mk_x(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 32'h1c000020));
    send(mk_v(32'h1c000024, 7, 1, 32'h77), 1, mk_x(1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 32'h1c000024));
    chk("full_in_ready", in_ready, 0);
    chk("full_busy", busy_dest_vec, 32'h0000_00C0);
    chk("stall_no_rf_we", rf_we, 0);
    repeat (2) @(posedge clk);
    #1 chk("stall_hold_ready", in_ready, 0);
    commit_stall = 0;
    #1 chk("full_no_passthru", {in_ready, rf_we}, 2'b01);
    send(mk_v(32'h1c000028, 8, 1, 32'h88), 1, mk_x(1, 8, 32'h88, 0, 0, 0, 0, 0, 0, 32'h1c000028));
    repeat (2) @(posedge clk);
    #1 chk("drain_retire", retire_cnt, 7);
    chk("drain_busy", busy_dest_vec, 0);
    commit_stall = 1;
    v = mk_v(32'h1c000040, 9, 1, 32'h99);
    v.excp = 1; v.en = 16'h0500;
    send(v, 1, mk_x(0, 0, 0, 0, 0, 0, 1, 0, 6'h0B, 32'h1c000040));
    send(mk_v(32'h1c000044, 10, 1, 32'hAA), 0, none);
    chk("excp_busy", busy_dest_vec, 32'h0000_0400);
    commit_stall = 0;
    #1 chk("excp_cycle", {excp_flush, in_ready, rf_we, ecode}, {3'b100, 6'h0B});
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      chk($sformatf("flush_hold%0d", j), in_ready, 0);
    end
    @(posedge clk); #1;
    chk("flush_release", in_ready, 1);
    chk("excp_busy_clear", busy_dest_vec, 0);
    chk("excp_retire", retire_cnt, 7);
    commit_stall = 1;
    v = mk_v(32'h1c000100, 0, 0, 0);
    v.ertn = 1;
    send(v, 1, mk_x(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1c000100));
    send(mk_v(32'h1c000104, 11, 1, 32'hBB), 0, none);
    commit_stall = 0;
    #1 chk("ertn_cycle", {ertn_flush, excp_flush, in_ready}, 3'b100);
    repeat (3) @(posedge clk);
    #1 chk("ertn_release", in_ready, 1);
    chk("ertn_retire", retire_cnt, 8);
    v = mk_v(32'h1c000200, 5, 1, 0);
    v.rfc = 1; v.cnum = 14'h006;
    send(v, 1, mk_x(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 32'h1c000200));
    chk("csrrd_wdata", {rf_waddr, rf_wdata}, {5'd5, 32'hDEADBEEF});
    v = mk_v(32'h1c000204, 12, 1, 0);
    v.rfc = 1; v.cwe = 1; v.cnum = 14'h006; v.cmask = 32'hFFFF0000; v.cdata = 32'h12345678;
    send(v, 1, mk_x(1, 12, 32'hDEADBEEF, 1, 32'hFFFF0000, 32'h12345678, 0, 0, 0, 32'h1c000204));
    chk("csrwr_strobe", {csr_we, csr_num}, {1'b1, 14'h006});
    @(posedge clk); #1;
    chk("csr_retire", retire_cnt, 10);
    v = mk_v(32'h1c000300, 0, 0, 0);
    v.ertn = 1;
    send(v, 1, mk_x(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1c000300));
    @(posedge clk); #1;
    chk("midflush_ready", in_ready, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_flush_ready", in_ready, 1);
    chk("rst_flush_retire", retire_cnt, 0);
    @(posedge clk); #1;
    chk("rst_flush_ready2", in_ready, 1);
    for (int k = 0; k < 17; k++)
      send(mk_v(32'h1c001000 + 4 * k, 1, 1, k), 1, mk_x(1, 1, k, 0, 0, 0, 0, 0, 0, 32'h1c001000 + 4 * k));
    @(posedge clk); #1;
    chk("wrap_retire", retire_cnt, 1);
    repeat (2) @(posedge clk);
    #1 chk("scoreboard_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
